// File: rtl/baud_tick_gen.sv
// Fractional baud divider: rx oversample tick, rx mid-bit strobe
// and tx bit tick, all single-cycle enables in the clk domain.
module baud_tick_gen #(
   parameter int CLOCK_RATE = 12000000,
   parameter int BAUD_RATE  = 19200,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int FRAC_BITS  = 4
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 enable,
   input  logic                 divLoad,
   input  logic [DIV_WIDTH-1:0] divInt,
   input  logic [FRAC_BITS-1:0] divFrac,
   input  logic                 rxResync,
   output logic                 rxTick,
   output logic                 rxMid,
   output logic                 txTick
);

   localparam int OW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam longint BDIV = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
   localparam longint DEF_INT_L = longint'(CLOCK_RATE) / BDIV;
   localparam longint DEF_FRAC_L =
      ((longint'(CLOCK_RATE) << FRAC_BITS) / BDIV) % (longint'(1) << FRAC_BITS);

   localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(DEF_INT_L);
   localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_FRAC_L);
   localparam logic [DIV_WIDTH-1:0] CNT_ONE  = 1;
   localparam logic [DIV_WIDTH:0]   LAST_ONE = 1;
   localparam logic [OW-1:0]        OVS_ONE  = 1;
   localparam logic [OW-1:0]        OVS_LAST = OW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0]        OVS_MID  = OW'(OVERSAMPLE / 2 - 1);

   logic [DIV_WIDTH-1:0] divInt_q, divInt_d;
   logic [FRAC_BITS-1:0] divFrac_q, divFrac_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [FRAC_BITS-1:0] acc_q, acc_d;
   logic                 extra_q, extra_d;
   logic [OW-1:0]        txOvs_q, txOvs_d;
   logic [OW-1:0]        rxOvs_q, rxOvs_d;
   logic                 rxTick_q, rxTick_d;
   logic                 rxMid_q, rxMid_d;
   logic                 txTick_q, txTick_d;

   logic [DIV_WIDTH-1:0] divEff;
   logic [DIV_WIDTH:0]   lastCnt;
   logic [FRAC_BITS:0]   accSum;
   logic                 periodEnd;

   // A zero divisor would never match; run it as divide-by-one.
   assign divEff    = (divInt_q == '0) ? CNT_ONE : divInt_q;
   assign lastCnt   = {1'b0, divEff} + {{DIV_WIDTH{1'b0}}, extra_q} - LAST_ONE;
   assign periodEnd = ({1'b0, cnt_q} == lastCnt);
   assign accSum    = {1'b0, acc_q} + {1'b0, divFrac_q};

   always_comb begin
      divInt_d  = divInt_q;
      divFrac_d = divFrac_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      extra_d   = extra_q;
      txOvs_d   = txOvs_q;
      rxOvs_d   = rxOvs_q;
      rxTick_d  = 1'b0;
      rxMid_d   = 1'b0;
      txTick_d  = 1'b0;
      if (divLoad) begin
         divInt_d  = divInt;
         divFrac_d = divFrac;
         cnt_d     = '0;
         acc_d     = '0;
         extra_d   = 1'b0;
         txOvs_d   = '0;
         rxOvs_d   = '0;
      end else if (rxResync) begin
         cnt_d   = '0;
         rxOvs_d = '0;
      end else if (enable) begin
         if (periodEnd) begin
            cnt_d            = '0;
            {extra_d, acc_d} = accSum;
            rxTick_d         = 1'b1;
            txTick_d         = (txOvs_q == OVS_LAST);
            rxMid_d          = (rxOvs_q == OVS_MID);
            txOvs_d = (txOvs_q == OVS_LAST) ? '0 : txOvs_q + OVS_ONE;
            rxOvs_d = (rxOvs_q == OVS_LAST) ? '0 : rxOvs_q + OVS_ONE;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         divInt_q  <= DEF_INT;
         divFrac_q <= DEF_FRAC;
         cnt_q     <= '0;
         acc_q     <= '0;
         extra_q   <= 1'b0;
         txOvs_q   <= '0;
         rxOvs_q   <= '0;
         rxTick_q  <= 1'b0;
         rxMid_q   <= 1'b0;
         txTick_q  <= 1'b0;
      end else begin
         divInt_q  <= divInt_d;
         divFrac_q <= divFrac_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         extra_q   <= extra_d;
         txOvs_q   <= txOvs_d;
         rxOvs_q   <= rxOvs_d;
         rxTick_q  <= rxTick_d;
         rxMid_q   <= rxMid_d;
         txTick_q  <= txTick_d;
      end
   end

   assign rxTick = rxTick_q;
   assign rxMid  = rxMid_q;
   assign txTick = txTick_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed and random stimulus checked
// against a closed-form model of tick periods and tick counts.
module tb_baud_tick_gen;

   localparam int OS = 16;
   localparam int FB = 4;

   logic        clk = 1'b0;
   logic        rstN;
   logic        enable;
   logic        divLoad;
   logic [15:0] divInt;
   logic [3:0]  divFrac;
   logic        rxResync;
   logic        rxTick;
   logic        rxMid;
   logic        txTick;

   int     compared   = 0;
   int     mismatched = 0;
   longint cyc = 0;

   // Model: divisor, ticks since load/reset, ticks since rx phase
   // restart, enabled cycles into the current period.
   longint mI, mF, n, rc, el;
   logic   e_rx, e_mid, e_tx;

   baud_tick_gen dut (
      .clk     (clk),
      .rstN    (rstN),
      .enable  (enable),
      .divLoad (divLoad),
      .divInt  (divInt),
      .divFrac (divFrac),
      .rxResync(rxResync),
      .rxTick  (rxTick),
      .rxMid   (rxMid),
      .txTick  (txTick)
   );

   always #5 clk = ~clk;

   // Length of the m-th period after a load: the integer part plus one
   // whenever the running fractional total crosses a whole cycle.
   function automatic longint period(longint m);
      if (m < 2) return mI;
      return mI + (((m - 1) * mF) / (1 << FB)) - (((m - 2) * mF) / (1 << FB));
   endfunction

   task automatic chk(string tag, logic obs, logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_int(string tag, longint obs, longint exp);
      compared++;
      assert (obs == exp) else begin
         mismatched++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic mreset();
      mI = 39; mF = 1; n = 0; rc = 0; el = 0;
      e_rx = 1'b0; e_mid = 1'b0; e_tx = 1'b0;
   endtask

   task automatic check_outs(string tag);
      chk({tag, ".rxTick"}, rxTick, e_rx);
      chk({tag, ".rxMid"},  rxMid,  e_mid);
      chk({tag, ".txTick"}, txTick, e_tx);
   endtask

   task automatic step();
      logic l, r, e;
      logic [15:0] di;
      logic [3:0]  df;
      l = divLoad; r = rxResync; e = enable; di = divInt; df = divFrac;
      @(posedge clk);
      cyc++;
      e_rx = 1'b0; e_mid = 1'b0; e_tx = 1'b0;
      if (l) begin
         mI = (di == 0) ? 1 : longint'(di);
         mF = longint'(df);
         n = 0; rc = 0; el = 0;
      end else if (r) begin
         rc = 0; el = 0;
      end else if (e) begin
         el++;
         if (el == period(n + 1)) begin
            n++; rc++; el = 0;
            e_rx  = 1'b1;
            e_tx  = (n % OS == 0);
            e_mid = (rc % OS == OS / 2);
         end
      end
      #1;
      check_outs("step");
   endtask

   task automatic run_sp(int nc, longint sp);
      longint lastTx;
      lastTx = -1;
      repeat (nc) begin
         step();
         if (txTick === 1'b1) begin
            if (lastTx >= 0 && sp > 0) chk_int("txSpacing", cyc - lastTx, sp);
            lastTx = cyc;
         end
      end
   endtask

   task automatic load(int di, int df);
      divLoad = 1'b1;
      divInt  = 16'(di);
      divFrac = 4'(df);
      step();
      divLoad = 1'b0;
   endtask

   initial begin
      int midAt;
      rstN = 1'b0; enable = 1'b0; divLoad = 1'b0; rxResync = 1'b0;
      divInt = '0; divFrac = '0;
      mreset();
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset");
      rstN = 1'b1;
      enable = 1'b1;

      // Default 39 + 1/16 divisor: tx bit period of 625 cycles.
      run_sp(2000, 625);

      // Runtime load 4 + 8/16: tx every 72 cycles.
      load(4, 8);
      run_sp(300, 72);

      // Resync mid-bit on an integer divisor of 10.
      load(10, 0);
      run_sp(400, 160);
      run_sp(37, 0);
      rxResync = 1'b1;
      step();
      rxResync = 1'b0;
      midAt = 0;
      for (int k = 1; k <= 80; k++) begin
         step();
         if (rxMid === 1'b1 && midAt == 0) midAt = k;
      end
      chk_int("resyncMid", midAt, 80);
      run_sp(500, 160);

      // Enable hold for 7 cycles mid-period.
      run_sp(3, 0);
      enable = 1'b0;
      run_sp(7, 0);
      enable = 1'b1;
      run_sp(60, 0);

      // Zero divisor clamps to one: tick every cycle, tx every 16.
      load(0, 0);
      run_sp(100, 16);

      // Load and resync together: load wins.
      rxResync = 1'b1;
      load(6, 3);
      rxResync = 1'b0;
      run_sp(300, 0);

      // Random loads, resyncs and enable gaps.
      for (int i = 0; i < 3000; i++) begin
         enable   = ($urandom_range(0, 9) != 0);
         rxResync = ($urandom_range(0, 149) == 0);
         divLoad  = ($urandom_range(0, 199) == 0);
         if (divLoad) begin
            divInt  = 16'($urandom_range(0, 12));
            divFrac = 4'($urandom);
         end
         step();
      end
      divLoad = 1'b0; rxResync = 1'b0; enable = 1'b1;

      // Asynchronous reset while ticks are high every cycle.
      load(0, 0);
      run_sp(5, 0);
      chk("preReset.rxTick", rxTick, 1'b1);
      #2;
      rstN = 1'b0;
      #1;
      mreset();
      check_outs("asyncReset");
      repeat (2) @(posedge clk);
      #1;
      check_outs("holdReset");
      rstN = 1'b1;
      run_sp(1400, 625);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Programmable successor to the fixed UART baud-rate divider.
- Produces single-cycle enable ticks, not derived toggling clocks:
  - an OVERSAMPLE-x receive tick;
  - a 1x transmit tick;
  - a receive mid-bit strobe that can be re-phased.
- The divisor has integer and fractional parts, can be loaded at runtime, and resets to a value computed from CLOCK_RATE/BAUD_RATE.
- Sits between the board clock and the UART rx/tx FSMs; all logic runs in the clk domain.

Parameters:
- CLOCK_RATE, 12000000: board clock frequency in Hz.
- BAUD_RATE, 19200: baud rate that sets the reset-time divisor.
- OVERSAMPLE, 16: rx ticks per bit period. Must be even and at least 4.
- DIV_WIDTH, 16: width of the integer divisor.
- FRAC_BITS, 4: width of the fractional divisor. The fraction is in units of 1/2^FRAC_BITS of a clk cycle.

Ports:
- clk, input, 1: board clock.
- rstN, input, 1: asynchronous, active-low reset.
- enable, input, 1: run the generator. When low, all counters hold and all ticks are 0.
- divLoad, input, 1: one-cycle strobe that latches divInt and divFrac.
- divInt, input, DIV_WIDTH: integer clk cycles per rx tick.
- divFrac, input, FRAC_BITS: fractional clk cycles per rx tick.
- rxResync, input, 1: strobe from the rx FSM on a start-bit edge. Restarts the rx bit phase.
- rxTick, output, 1: one-cycle pulse at OVERSAMPLE x baud.
- rxMid, output, 1: one-cycle pulse at the middle of each rx bit.
- txTick, output, 1: one-cycle pulse once per bit period.

Behaviour:
- Reset (rstN=0, asynchronous):
  - rxTick=0, rxMid=0, txTick=0.
  - Counters and the accumulator are cleared.
  - Divisor registers load their defaults:
    - DEF_INT = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE).
    - DEF_FRAC = (CLOCK_RATE*2^FRAC_BITS/(BAUD_RATE*OVERSAMPLE)) mod 2^FRAC_BITS.
    - With the default parameters this gives DEF_INT=39, DEF_FRAC=1.
- Output register timing: all outputs are registered. Each tick is high for exactly one clk cycle.
- Base divider (period generation):
  - The cycle counter cnt (DIV_WIDTH bits) counts up from 0.
  - The current period is P = divIntReg + extra, where extra is 0 or 1.
  - When cnt == P-1, the next edge asserts rxTick and sets cnt=0.
  - On the same edge, {carry, acc} = acc + divFracReg (FRAC_BITS+1 bits), and extra <= carry.
  - Long-run mean period = divIntReg + divFracReg/2^FRAC_BITS.
- Divisor clamp: divIntReg of 0 is treated as 1. Divisor 1 with fraction 0 gives rxTick on every enabled cycle.
- Divisor load:
  - A divLoad edge latches divInt and divFrac.
  - It also clears cnt, acc, extra, txOvs and rxOvs, and forces all ticks to 0 that cycle.
  - The first rxTick then occurs divInt cycles after the load edge.
- Tx path:
  - txOvs counts rxTicks from 0 to OVERSAMPLE-1 and wraps.
  - txTick asserts on the same cycle as the rxTick that wraps txOvs from OVERSAMPLE-1 to 0.
  - rxResync does not affect txOvs.
- Rx phase:
  - rxOvs counts rxTicks from 0 to OVERSAMPLE-1 and wraps.
  - rxMid asserts with the rxTick on which rxOvs == OVERSAMPLE/2-1.
- rxResync:
  - Sets rxOvs=0 and cnt=0 and suppresses rxTick and rxMid for that cycle.
  - Leaves acc and extra unchanged.
  - So the first rxMid follows OVERSAMPLE/2 rx ticks later, at roughly half a bit period.
  - txOvs is not reset by rxResync, but the cleared cnt shifts the shared tick timing for tx as well.
- Priority (highest first): rstN, then divLoad, then rxResync, then normal counting.
  - enable=0 blocks counting and ticks.
  - divLoad and rxResync are still honoured while enable=0.
- Wrap-around: cnt never exceeds P-1. Loading a smaller divisor mid-period is safe because divLoad clears cnt.
- Mid-operation reset: an asynchronous reset in the middle of a period returns the block to the reset state immediately. The default divisor is restored.

Test Plan:
- Default divisor: default parameters, reset released, enable=1 for 2000 cycles.
  - rxTick spacing is 39 cycles, with 40 on every 16th tick.
  - Sum over 16 ticks = 625 cycles; txTick spacing = 625 cycles.
- Runtime load: divLoad with divInt=4, divFrac=8.
  - Tick spacing alternates 4,5,4,5,… (first tick 4 cycles after the load edge).
  - txTick every 72 cycles; rxMid on every 8th rxTick of each 16.
- Resync: pulse rxResync mid-bit with divInt=10, divFrac=0.
  - No rxTick on that cycle; next rxTick 10 cycles later.
  - rxMid exactly 80 cycles after the resync edge.
  - txTick cadence stays 160 cycles apart between resyncs; it shifts by at most one partial period at a resync.
- Enable hold: drop enable for 7 cycles mid-period.
  - No ticks during the hold; the period resumes from the held cnt and ends exactly 7 cycles later than planned.
- Edge cases:
  - divInt=0, divFrac=0 → rxTick high on every enabled cycle; txTick every 16 cycles.
  - divLoad and rxResync in the same cycle → divLoad semantics apply (all counters cleared).
- Async reset: assert rstN=0 asynchronously mid-period.
  - Outputs go to 0 without waiting for a clk edge.
  - After release, the divisor is again 39/1.
